// File: rtl/cnn_frame_rx_if.sv
// Result-stream bundle from the conv datapath into the frame receiver.
// The producer drives through the master modport; the receiver samples through slave.
interface cnn_frame_rx_if #(
   parameter int W_DATA = 8
);
   logic              i_vsync_run;
   logic              i_hsync_run;
   logic              i_data_valid;
   logic [W_DATA-1:0] i_data;

   modport master (
      output i_vsync_run,
      output i_hsync_run,
      output i_data_valid,
      output i_data
   );

   modport slave (
      input  i_vsync_run,
      input  i_hsync_run,
      input  i_data_valid,
      input  i_data
   );
endinterface

// File: rtl/cnn_frame_rx.sv
// Frame receiver: rebuilds row/col from the vsync/hsync/valid result stream and
// writes pixels linearly into the frame buffer. Optional checksum: CNN_RX_CHECKSUM_EN.
module cnn_frame_rx #(
   parameter int W_SIZE       = 12,
   parameter int W_FRAME_SIZE = 2*W_SIZE+1,
   parameter int W_DATA       = 8
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [W_SIZE-1:0]       q_width,
   input  logic [W_SIZE-1:0]       q_height,
   input  logic                    q_clr_err,
   cnn_frame_rx_if.slave           i_rx,
   output logic                    o_wr_en,
   output logic [W_FRAME_SIZE-1:0] o_wr_addr,
   output logic [W_DATA-1:0]       o_wr_data,
   output logic [W_SIZE-1:0]       o_row,
   output logic [W_SIZE-1:0]       o_col,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic                    o_line_err,
   output logic                    o_frame_err,
   output logic [31:0]             o_checksum
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SYNC = 2'd1,
      ST_RECV = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [W_SIZE-1:0]       r_row;
   logic [W_SIZE-1:0]       r_col;
   logic [W_FRAME_SIZE-1:0] r_pix_cnt;
   logic [W_FRAME_SIZE-1:0] r_row_base;

   logic [W_SIZE-1:0]       w_row_nxt;
   logic [W_SIZE-1:0]       w_col_nxt;
   logic [W_FRAME_SIZE-1:0] w_pix_nxt;
   logic [W_FRAME_SIZE-1:0] w_base_nxt;

   logic [W_SIZE-1:0]       w_row_acc;
   logic [W_SIZE-1:0]       w_col_acc;
   logic [W_FRAME_SIZE-1:0] w_pix_acc;
   logic [W_FRAME_SIZE-1:0] w_base_acc;

   logic                    w_accept;
   logic                    w_frame_start;
   logic                    w_frame_end;
   logic                    w_line_err_set;
   logic                    w_frame_err_set;

   logic                    r_wr_en;
   logic [W_FRAME_SIZE-1:0] r_wr_addr;
   logic [W_DATA-1:0]       r_wr_data;
   logic                    r_frame_done;
   logic                    r_line_err;
   logic                    r_frame_err;

   logic [W_SIZE-1:0]       w_width_m1;
   logic [W_SIZE-1:0]       w_height_m1;
   logic [W_FRAME_SIZE-1:0] w_width_ext;
   logic                    w_last_col;
   logic                    w_last_row;

   assign w_width_m1  = q_width - W_SIZE'(1);
   assign w_height_m1 = q_height - W_SIZE'(1);
   assign w_width_ext = W_FRAME_SIZE'(q_width);
   assign w_last_col  = (r_col == w_width_m1);
   assign w_last_row  = (r_row == w_height_m1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= ST_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_pix_cnt  <= '0;
         r_row_base <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_row      <= w_row_nxt;
         r_col      <= w_col_nxt;
         r_pix_cnt  <= w_pix_nxt;
         r_row_base <= w_base_nxt;
      end
   end

   // NOTE: every combinational output gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      w_state_nxt     = r_state;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_pix_nxt       = r_pix_cnt;
      w_base_nxt      = r_row_base;
      w_row_acc       = r_row;
      w_col_acc       = r_col;
      w_pix_acc       = r_pix_cnt;
      w_base_acc      = r_row_base;
      w_accept        = 1'b0;
      w_frame_start   = 1'b0;
      w_frame_end     = 1'b0;
      w_line_err_set  = 1'b0;
      w_frame_err_set = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_rx.i_vsync_run) begin
               w_state_nxt   = ST_SYNC;
               w_frame_start = 1'b1;
               w_row_nxt     = '0;
               w_col_nxt     = '0;
               w_pix_nxt     = '0;
               w_base_nxt    = '0;
            end
         end

         default: begin
            // A vsync after pixels have arrived means the producer restarted the frame.
            if (i_rx.i_vsync_run && (r_state == ST_RECV || r_pix_cnt != '0)) begin
               w_state_nxt     = ST_SYNC;
               w_frame_start   = 1'b1;
               w_frame_err_set = 1'b1;
               w_row_nxt       = '0;
               w_col_nxt       = '0;
               w_pix_nxt       = '0;
               w_base_nxt      = '0;
            end else begin
               if (r_state == ST_SYNC && !i_rx.i_vsync_run) begin
                  w_state_nxt = ST_RECV;
               end

               if (i_rx.i_data_valid) begin
                  w_accept  = 1'b1;
                  w_pix_acc = r_pix_cnt + W_FRAME_SIZE'(1);
                  if (w_last_col) begin
                     w_frame_end = w_last_row;
                     w_col_acc   = '0;
                     w_row_acc   = r_row + W_SIZE'(1);
                     w_base_acc  = r_row_base + w_width_ext;
                  end else begin
                     w_col_acc = r_col + W_SIZE'(1);
                  end
               end

               // Short-line check sees the column after this cycle's pixel, if any.
               if (r_state == ST_RECV && i_rx.i_hsync_run && w_col_acc != '0) begin
                  w_line_err_set = 1'b1;
                  w_frame_end    = (w_row_acc == w_height_m1);
                  w_col_acc      = '0;
                  w_row_acc      = w_row_acc + W_SIZE'(1);
                  w_base_acc     = w_base_acc + w_width_ext;
                  w_pix_acc      = w_base_acc;
               end

               if (w_frame_end) begin
                  w_state_nxt = ST_IDLE;
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
                  w_pix_nxt   = '0;
                  w_base_nxt  = '0;
               end else begin
                  w_row_nxt  = w_row_acc;
                  w_col_nxt  = w_col_acc;
                  w_pix_nxt  = w_pix_acc;
                  w_base_nxt = w_base_acc;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
         r_frame_done <= 1'b0;
         r_line_err   <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_wr_en      <= w_accept;
         r_frame_done <= w_frame_end;
         if (w_accept) begin
            r_wr_addr <= r_pix_cnt;
            r_wr_data <= i_rx.i_data;
         end
         // A flag raised in the clear cycle survives the clear.
         r_line_err  <= w_line_err_set  | (r_line_err  & ~q_clr_err);
         r_frame_err <= w_frame_err_set | (r_frame_err & ~q_clr_err);
      end
   end

`ifdef CNN_RX_CHECKSUM_EN
   logic [31:0] r_acc;
   logic [31:0] r_checksum;
   logic [31:0] w_sum;

   assign w_sum = w_accept ? (r_acc + 32'(i_rx.i_data)) : r_acc;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_acc      <= '0;
         r_checksum <= '0;
      end else begin
         if (w_frame_start) begin
            r_acc <= '0;
         end else if (w_accept) begin
            r_acc <= w_sum;
         end
         if (w_frame_end) begin
            r_checksum <= w_sum;
         end
      end
   end

   assign o_checksum = r_checksum;
`else
   assign o_checksum = '0;
`endif

   assign o_wr_en      = r_wr_en;
   assign o_wr_addr    = r_wr_addr;
   assign o_wr_data    = r_wr_data;
   assign o_row        = r_row;
   assign o_col        = r_col;
   assign o_busy       = (r_state != ST_IDLE);
   assign o_frame_done = r_frame_done;
   assign o_line_err   = r_line_err;
   assign o_frame_err  = r_frame_err;

endmodule
